// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: holds one decoded instruction behind a valid/ready handshake,
// forwards from EX/MEM and MEM/WB, stalls on load-use and selects the ALU operands.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [3:0]      alu_op_i,
  input  logic [1:0]      src1_sel_i,
  input  logic [1:0]      src2_sel_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            flush_i,
  input  logic            ready_i,
  input  logic [4:0]      exm_rd_i,
  input  logic            exm_reg_write_i,
  input  logic            exm_mem_read_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [4:0]      mwb_rd_i,
  input  logic            mwb_reg_write_i,
  input  logic [XLEN-1:0] mwb_result_i,
  output logic            valid_o,
  output logic [XLEN-1:0] operand1_o,
  output logic [XLEN-1:0] operand2_o,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic [XLEN-1:0] pc_o,
  output logic            hazard_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [3:0]      alu_op_q;
  logic [1:0]      src1_sel_q, src2_sel_q;
  logic            reg_write_q, mem_read_q;

  logic            hazard;
  logic            load;
  logic [XLEN-1:0] fwd1, fwd2;

  assign hazard  = valid_q && exm_mem_read_i && exm_reg_write_i && (exm_rd_i != 5'd0) &&
                   ((exm_rd_i == rs1_q) || (exm_rd_i == rs2_q));
  assign ready_o = !hazard && (!valid_q || ready_i);
  assign load    = valid_i && ready_o;

  // A beat accepted during a flush is dropped; upstream is flushed alongside us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      src1_sel_q  <= '0;
      src2_sel_q  <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      if (flush_i)
        valid_q <= 1'b0;
      else if (load)
        valid_q <= 1'b1;
      else if (valid_q && ready_i && !hazard)
        valid_q <= 1'b0;
      if (load && !flush_i) begin
        pc_q        <= pc_i;
        rs1_data_q  <= rs1_data_i;
        rs2_data_q  <= rs2_data_i;
        imm_q       <= imm_i;
        rs1_q       <= rs1_addr_i;
        rs2_q       <= rs2_addr_i;
        rd_q        <= rd_addr_i;
        alu_op_q    <= alu_op_i;
        src1_sel_q  <= src1_sel_i;
        src2_sel_q  <= src2_sel_i;
        reg_write_q <= reg_write_i;
        mem_read_q  <= mem_read_i;
      end
    end
  end

  // The younger result in EX/MEM wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd1 = rs1_data_q;
    if (rs1_q != 5'd0 && exm_reg_write_i && exm_rd_i == rs1_q)
      fwd1 = exm_result_i;
    else if (rs1_q != 5'd0 && mwb_reg_write_i && mwb_rd_i == rs1_q)
      fwd1 = mwb_result_i;
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (rs2_q != 5'd0 && exm_reg_write_i && exm_rd_i == rs2_q)
      fwd2 = exm_result_i;
    else if (rs2_q != 5'd0 && mwb_reg_write_i && mwb_rd_i == rs2_q)
      fwd2 = mwb_result_i;
  end

  always_comb begin
    operand1_o = '0;
    if (!src1_sel_q[1])
      operand1_o = src1_sel_q[0] ? pc_q : fwd1;
  end

  always_comb begin
    operand2_o = '0;
    case (src2_sel_q)
      2'b00:   operand2_o = fwd2;
      2'b01:   operand2_o = imm_q;
      2'b10:   operand2_o = {{(XLEN-3){1'b0}}, 3'd4};
      default: operand2_o = '0;
    endcase
  end

  assign store_data_o = fwd2;
  assign valid_o      = valid_q && !hazard;
  assign hazard_o     = hazard;
  assign alu_op_o     = alu_op_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD = 4'h0;

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [1:0]  s1, s2;
    logic        rw, mr;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i, ready_i, flush_i;
  ins_t drv;
  logic [4:0]  exm_rd_i, mwb_rd_i;
  logic        exm_reg_write_i, exm_mem_read_i, mwb_reg_write_i;
  logic [31:0] exm_result_i, mwb_result_i;

  logic        ready_o, valid_o, reg_write_o, mem_read_o, hazard_o;
  logic [31:0] operand1_o, operand2_o, store_data_o, pc_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  rd_addr_o;

  int total = 0;
  int bad = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(drv.pc), .rs1_data_i(drv.rs1d), .rs2_data_i(drv.rs2d), .imm_i(drv.imm),
    .rs1_addr_i(drv.rs1), .rs2_addr_i(drv.rs2), .rd_addr_i(drv.rd),
    .alu_op_i(drv.op), .src1_sel_i(drv.s1), .src2_sel_i(drv.s2),
    .reg_write_i(drv.rw), .mem_read_i(drv.mr), .flush_i(flush_i), .ready_i(ready_i),
    .exm_rd_i(exm_rd_i), .exm_reg_write_i(exm_reg_write_i), .exm_mem_read_i(exm_mem_read_i),
    .exm_result_i(exm_result_i), .mwb_rd_i(mwb_rd_i), .mwb_reg_write_i(mwb_reg_write_i),
    .mwb_result_i(mwb_result_i), .valid_o(valid_o), .operand1_o(operand1_o),
    .operand2_o(operand2_o), .alu_op_o(alu_op_o), .store_data_o(store_data_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .pc_o(pc_o), .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction the stage should be holding, if any.
  logic m_valid;
  ins_t m_ins;

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
    if (rs != 0 && exm_reg_write_i && exm_rd_i == rs) return exm_result_i;
    if (rs != 0 && mwb_reg_write_i && mwb_rd_i == rs) return mwb_result_i;
    return d;
  endfunction

  function automatic logic modelHazard();
    return m_valid && exm_mem_read_i && exm_reg_write_i && exm_rd_i != 0 &&
           (exm_rd_i == m_ins.rs1 || exm_rd_i == m_ins.rs2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic hz, rdy;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ins = '0;
    end else begin
      hz = modelHazard();
      rdy = !hz && (!m_valid || ready_i);
      if (valid_i && rdy) m_ins = drv;
      if (flush_i) m_valid = 1'b0;
      else if (valid_i && rdy) m_valid = 1'b1;
      else if (m_valid && ready_i && !hz) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic hz;
    logic [31:0] e1, e2;
    if (rst_n) begin
      hz = modelHazard();
      checkOutput("hazard_o", hazard_o, hz);
      checkOutput("valid_o", valid_o, m_valid && !hz);
      checkOutput("ready_o", ready_o, !hz && (!m_valid || ready_i));
      if (m_valid) begin
        case (m_ins.s1)
          2'd0: e1 = fwd(m_ins.rs1, m_ins.rs1d);
          2'd1: e1 = m_ins.pc;
          default: e1 = 32'd0;
        endcase
        case (m_ins.s2)
          2'd0: e2 = fwd(m_ins.rs2, m_ins.rs2d);
          2'd1: e2 = m_ins.imm;
          2'd2: e2 = 32'd4;
          default: e2 = 32'd0;
        endcase
        checkOutput("operand1_o", operand1_o, e1);
        checkOutput("operand2_o", operand2_o, e2);
        checkOutput("store_data_o", store_data_o, fwd(m_ins.rs2, m_ins.rs2d));
        checkOutput("alu_op_o", alu_op_o, m_ins.op);
        checkOutput("rd_addr_o", rd_addr_o, m_ins.rd);
        checkOutput("reg_write_o", reg_write_o, m_ins.rw);
        checkOutput("mem_read_o", mem_read_o, m_ins.mr);
        checkOutput("pc_o", pc_o, m_ins.pc);
      end
    end
  end

  function automatic ins_t makeIns(input logic [31:0] pc, input logic [4:0] rs1,
                                   input logic [31:0] rs1d, input logic [4:0] rs2,
                                   input logic [31:0] rs2d, input logic [31:0] imm,
                                   input logic [1:0] s1, input logic [1:0] s2,
                                   input logic [4:0] rd);
    ins_t t;
    t = '0;
    t.pc = pc; t.rs1 = rs1; t.rs1d = rs1d; t.rs2 = rs2; t.rs2d = rs2d;
    t.imm = imm; t.s1 = s1; t.s2 = s2; t.rd = rd; t.op = ALU_ADD; t.rw = 1'b1;
    return t;
  endfunction

  task automatic applyStimulus(input ins_t ins, input logic v, input logic rdy);
    drv = ins;
    valid_i = v;
    ready_i = rdy;
    flush_i = 1'b0;
  endtask

  task automatic setNoForward();
    exm_rd_i = 0; exm_reg_write_i = 0; exm_mem_read_i = 0; exm_result_i = 0;
    mwb_rd_i = 0; mwb_reg_write_i = 0; mwb_result_i = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, valid_o, 1'b0);
    checkOutput({tag, "_hazard"}, hazard_o, 1'b0);
    checkOutput({tag, "_ready"}, ready_o, 1'b1);
    checkOutput({tag, "_aluop"}, alu_op_o, 4'h0);
    checkOutput({tag, "_op1"}, operand1_o, 32'h0);
    checkOutput({tag, "_op2"}, operand2_o, 32'h0);
    checkOutput({tag, "_store"}, store_data_o, 32'h0);
    checkOutput({tag, "_rd"}, rd_addr_o, 5'd0);
    checkOutput({tag, "_rw"}, reg_write_o, 1'b0);
    checkOutput({tag, "_mr"}, mem_read_o, 1'b0);
    checkOutput({tag, "_pc"}, pc_o, 32'h0);
  endtask

  task automatic randomize_inputs();
    ins_t t;
    t.pc = $urandom; t.rs1d = $urandom; t.rs2d = $urandom; t.imm = $urandom;
    t.rs1 = 5'($urandom_range(0, 3)); t.rs2 = 5'($urandom_range(0, 3));
    t.rd = 5'($urandom_range(0, 31)); t.op = 4'($urandom);
    t.s1 = 2'($urandom); t.s2 = 2'($urandom);
    t.rw = 1'($urandom); t.mr = 1'($urandom);
    drv = t;
    valid_i = ($urandom % 4) != 0;
    ready_i = ($urandom % 4) != 0;
    flush_i = ($urandom % 16) == 0;
    exm_rd_i = 5'($urandom_range(0, 3)); exm_reg_write_i = 1'($urandom);
    exm_mem_read_i = ($urandom % 3) == 0; exm_result_i = $urandom;
    mwb_rd_i = 5'($urandom_range(0, 3)); mwb_reg_write_i = 1'($urandom);
    mwb_result_i = $urandom;
  endtask

  initial begin
    setNoForward();
    applyStimulus(makeIns(32'h40, 5'd1, 32'h5, 5'd2, 32'h6, 32'h7, 2'd0, 2'd0, 5'd3), 1'b1, 1'b1);
    #1 checkResetValues("init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD with immediate operand, no forwarding
    applyStimulus(makeIns(32'h100, 5'd5, 32'h10, 5'd6, 32'h0, 32'hFFFF_FFFF, 2'd0, 2'd1, 5'd9), 1'b1, 1'b1);
    @(negedge clk) checkOutput("add_ready", ready_o, 1'b1);
    nextCycle(); valid_i = 1'b0;
    @(negedge clk);
    checkOutput("add_valid", valid_o, 1'b1);
    checkOutput("add_op1", operand1_o, 32'h10);
    checkOutput("add_op2", operand2_o, 32'hFFFF_FFFF);
    checkOutput("add_aluop", alu_op_o, ALU_ADD);

    // Forwarding priority on rs1
    nextCycle();
    applyStimulus(makeIns(32'h200, 5'd3, 32'h55, 5'd0, 32'h66, 32'h0, 2'd0, 2'd0, 5'd4), 1'b1, 1'b1);
    nextCycle();
    valid_i = 1'b0; ready_i = 1'b0;
    exm_rd_i = 5'd3; exm_reg_write_i = 1'b1; exm_result_i = 32'hAAAA;
    mwb_rd_i = 5'd3; mwb_reg_write_i = 1'b1; mwb_result_i = 32'hBBBB;
    @(negedge clk) checkOutput("fwd_exm", operand1_o, 32'hAAAA);
    nextCycle(); exm_reg_write_i = 1'b0;
    @(negedge clk) checkOutput("fwd_mwb", operand1_o, 32'hBBBB);
    nextCycle();
    applyStimulus(makeIns(32'h204, 5'd0, 32'h77, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 5'd4), 1'b1, 1'b1);
    exm_rd_i = 5'd0; exm_reg_write_i = 1'b1; mwb_rd_i = 5'd0;
    nextCycle(); valid_i = 1'b0;
    @(negedge clk) checkOutput("fwd_x0", operand1_o, 32'h77);

    // Load-use stall then MEM/WB forward
    nextCycle(); setNoForward();
    applyStimulus(makeIns(32'h300, 5'd1, 32'h11, 5'd7, 32'h99, 32'h0, 2'd0, 2'd0, 5'd8), 1'b1, 1'b1);
    nextCycle();
    drv = makeIns(32'h500, 5'd1, 32'h1, 5'd1, 32'h1, 32'h0, 2'd0, 2'd0, 5'd1);
    exm_rd_i = 5'd7; exm_reg_write_i = 1'b1; exm_mem_read_i = 1'b1; exm_result_i = 32'hDEAD;
    @(negedge clk);
    checkOutput("lu_hazard", hazard_o, 1'b1);
    checkOutput("lu_valid", valid_o, 1'b0);
    checkOutput("lu_ready", ready_o, 1'b0);
    nextCycle();
    valid_i = 1'b0; exm_reg_write_i = 1'b0; exm_mem_read_i = 1'b0;
    mwb_rd_i = 5'd7; mwb_reg_write_i = 1'b1; mwb_result_i = 32'h1234;
    @(negedge clk);
    checkOutput("lu_hazard_clr", hazard_o, 1'b0);
    checkOutput("lu_valid_after", valid_o, 1'b1);
    checkOutput("lu_op2", operand2_o, 32'h1234);
    checkOutput("lu_store", store_data_o, 32'h1234);
    checkOutput("lu_pc_held", pc_o, 32'h300);

    // Backpressure then flush
    nextCycle(); setNoForward();
    applyStimulus(makeIns(32'h600, 5'd2, 32'hCAFE, 5'd0, 32'h0, 32'h0, 2'd0, 2'd2, 5'd5), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(makeIns(32'h700, 5'd1, 32'h1, 5'd1, 32'h1, 32'h0, 2'd0, 2'd0, 5'd1), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp_ready", ready_o, 1'b0);
      checkOutput("bp_valid", valid_o, 1'b1);
      checkOutput("bp_op1", operand1_o, 32'hCAFE);
      checkOutput("bp_op2", operand2_o, 32'h4);
      checkOutput("bp_pc", pc_o, 32'h600);
    end
    nextCycle(); ready_i = 1'b1; flush_i = 1'b1;
    nextCycle(); flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk) checkOutput("flush_valid", valid_o, 1'b0);

    // Back-to-back throughput
    for (int k = 0; k <= 8; k++) begin
      nextCycle();
      if (k < 8)
        applyStimulus(makeIns(32'h1000 + 4 * k, 5'd0, 32'h0, 5'd0, 32'h0, 32'(k), 2'd1, 2'd1, 5'(k)), 1'b1, 1'b1);
      else
        valid_i = 1'b0;
      @(negedge clk);
      if (k < 8) checkOutput("b2b_ready", ready_o, 1'b1);
      if (k >= 1) begin
        checkOutput("b2b_valid", valid_o, 1'b1);
        checkOutput("b2b_pc", pc_o, 32'h1000 + 4 * (k - 1));
      end
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      randomize_inputs();
    end

    // Mid-stream asynchronous reset
    nextCycle();
    randomize_inputs(); valid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkResetValues("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    setNoForward();
    applyStimulus(makeIns(32'h2000, 5'd1, 32'h3, 5'd2, 32'h4, 32'h0, 2'd0, 2'd0, 5'd6), 1'b1, 1'b1);
    @(negedge clk) checkOutput("post_rst_ready", ready_o, 1'b1);
    nextCycle(); valid_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", valid_o, 1'b1);
    checkOutput("post_rst_pc", pc_o, 32'h2000);

    nextCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
